// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register indices, CTRL layout and
// the byte-strobe write merge helper.
package apb_timer_pkg;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_LOAD   = 4'd1;
    localparam logic [3:0] REG_COUNT  = 4'd2;
    localparam logic [3:0] REG_STATUS = 4'd3;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_IRQEN   = 2;
    localparam int unsigned CTRL_PS_LSB  = 8;
    localparam int unsigned CTRL_PS_MSB  = 15;

    // Full 32-bit image of CTRL; the reserved fields only ever hold zero.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  prescale;
        logic [4:0]  rsvd_lo;
        logic        irqen;
        logic        oneshot;
        logic        en;
    } ctrl_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Clock divider: ticks once every (prescale+1) cycles while enabled;
// the count restarts from zero whenever disabled or cleared.
module apb_timer_prescaler #(
    parameter int PS_WIDTH = 8
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                en,
    input  logic                clr,
    input  logic [PS_WIDTH-1:0] prescale,
    output logic                tick
);

    logic [PS_WIDTH-1:0] ps_cnt;

    assign tick = en & (ps_cnt == prescale);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ps_cnt <= '0;
        end else if (!en || clr || tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB4 down-counting timer: zero-wait register file, prescaled 32-bit
// counter with auto-reload / one-shot, sticky expiry flag and level IRQ.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int PDATA_SIZE = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int PS_WIDTH   = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [3:0]              PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    irq_o
);

    localparam logic [7:0] PS_MASK = 8'((1 << PS_WIDTH) - 1);

    ctrl_t                ctrl;
    logic [CNT_WIDTH-1:0] load;
    logic [CNT_WIDTH-1:0] count;
    logic                 exp_flag;
    logic                 tick;

    logic access, mapped, wr, rd;
    logic ctrl_wr, load_wr, count_wr, status_wr;
    logic expire;

    assign access    = PSEL & PENABLE;
    assign mapped    = (PADDR <= REG_STATUS);
    assign wr        = access & PWRITE & mapped;
    assign rd        = access & ~PWRITE & mapped;
    assign ctrl_wr   = wr & (PADDR == REG_CTRL);
    assign load_wr   = wr & (PADDR == REG_LOAD);
    assign count_wr  = wr & (PADDR == REG_COUNT);
    assign status_wr = wr & (PADDR == REG_STATUS);

    // A direct COUNT write pre-empts the tick, so it can never expire.
    assign expire = tick & ~count_wr & (count == '0);

    apb_timer_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .en       (ctrl.en),
        .clr      (ctrl_wr),
        .prescale (ctrl.prescale[PS_WIDTH-1:0]),
        .tick     (tick)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl <= '0;
        end else begin
            if (expire && ctrl.oneshot) ctrl.en <= 1'b0;
            // Later assignment wins: a written EN overrides the one-shot stop.
            if (ctrl_wr && PSTRB[0]) begin
                ctrl.en      <= PWDATA[CTRL_EN];
                ctrl.oneshot <= PWDATA[CTRL_ONESHOT];
                ctrl.irqen   <= PWDATA[CTRL_IRQEN];
            end
            if (ctrl_wr && PSTRB[1]) begin
                ctrl.prescale <= PWDATA[CTRL_PS_MSB:CTRL_PS_LSB] & PS_MASK;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            load <= '0;
        end else if (load_wr) begin
            load <= CNT_WIDTH'(strb_merge(32'(load), PWDATA, PSTRB));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count <= '0;
        end else if (count_wr) begin
            count <= CNT_WIDTH'(strb_merge(32'(count), PWDATA, PSTRB));
        end else if (tick) begin
            if (count != '0) begin
                count <= count - CNT_WIDTH'(1);
            end else if (!ctrl.oneshot) begin
                count <= load;
            end
        end
    end

    // Hardware set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (status_wr && PSTRB[0] && PWDATA[0]) begin
            exp_flag <= 1'b0;
        end
    end

    assign irq_o   = exp_flag & ctrl.irqen;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (PADDR)
                REG_CTRL:   PRDATA = PDATA_SIZE'(ctrl);
                REG_LOAD:   PRDATA = PDATA_SIZE'(load);
                REG_COUNT:  PRDATA = PDATA_SIZE'(count);
                REG_STATUS: PRDATA = PDATA_SIZE'(exp_flag);
                default:    PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios with literal expectations plus
// randomized APB traffic compared every cycle against a behavioural model.
module tb_apb_timer;

    logic        PCLK    = 1'b0;
    logic        PRESET  = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [3:0]  PSTRB   = 4'h0;
    logic [3:0]  PADDR   = 4'h0;
    logic [31:0] PWDATA  = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    apb_timer #(
        .PDATA_SIZE (32),
        .CNT_WIDTH  (32),
        .PS_WIDTH   (8)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PSTRB   (PSTRB),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq_o   (irq_o)
    );

    always #5 PCLK = ~PCLK;

    // Behavioural model state
    logic        m_en, m_os, m_ie, m_exp;
    logic [7:0]  m_pre;
    logic [31:0] m_load, m_count;
    int unsigned m_ps;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_os = 1'b0; m_ie = 1'b0; m_exp = 1'b0;
        m_pre = 8'h0; m_load = 32'h0; m_count = 32'h0; m_ps = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'd0:    return {16'h0, m_pre, 5'h0, m_ie, m_os, m_en};
            4'd1:    return m_load;
            4'd2:    return m_count;
            4'd3:    return {31'h0, m_exp};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock using the bus values present at the edge.
    task automatic model_step();
        logic        acc, wr, wctrl, wcnt, tick, expire;
        logic [31:0] mask;
        acc    = PSEL && PENABLE;
        wr     = acc && PWRITE && (PADDR < 4'd4);
        wctrl  = wr && (PADDR == 4'd0);
        wcnt   = wr && (PADDR == 4'd2);
        mask   = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
        tick   = m_en && (m_ps == int'(m_pre));
        expire = tick && !wcnt && (m_count == 32'h0);

        if (!m_en || wctrl) m_ps = 0;
        else                m_ps = (m_ps + 1) % (int'(m_pre) + 1);

        if (wcnt)
            m_count = (m_count & ~mask) | (PWDATA & mask);
        else if (tick)
            m_count = (m_count != 0) ? m_count - 1 : (m_os ? 32'h0 : m_load);

        if (wr && PADDR == 4'd1) m_load = (m_load & ~mask) | (PWDATA & mask);

        if (expire && m_os) m_en = 1'b0;
        if (wctrl && PSTRB[0]) begin
            m_en = PWDATA[0]; m_os = PWDATA[1]; m_ie = PWDATA[2];
        end
        if (wctrl && PSTRB[1]) m_pre = PWDATA[15:8];

        if (expire) m_exp = 1'b1;
        else if (wr && PADDR == 4'd3 && PSTRB[0] && PWDATA[0]) m_exp = 1'b0;
    endtask

    // Compare process: every falling edge outside reset.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            check("prdata", PRDATA,
                  (PSEL && PENABLE && !PWRITE) ? model_read(PADDR) : 32'h0);
            check("pslverr", 32'(PSLVERR), 32'(PSEL && PENABLE && (PADDR > 4'd3)));
            check("irq", 32'(irq_o), 32'(m_exp & m_ie));
            check("pready", 32'(PREADY), 32'h1);
        end
    end

    task automatic cycle();
        @(posedge PCLK);
        if (!PRESET) model_step();
        #1;
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
        cycle();
        PENABLE = 1'b1;
        cycle();
        idle();
    endtask

    task automatic apb_read_check(input logic [3:0] a, input logic [31:0] req, input string name);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        cycle();
        PENABLE = 1'b1;
        #1;
        check(name, PRDATA, req);
        cycle();
        idle();
    endtask

    logic [31:0] seq [11] = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) cycle();
        PRESET = 1'b0;
        cycle();

        // Reset state
        apb_read_check(4'd0, 32'h0, "rst_ctrl");
        apb_read_check(4'd1, 32'h0, "rst_load");
        apb_read_check(4'd2, 32'h0, "rst_count");
        apb_read_check(4'd3, 32'h0, "rst_status");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd5;
        cycle();
        PENABLE = 1'b1;
        #1;
        check("idx5_pslverr", 32'(PSLVERR), 32'h1);
        check("idx5_prdata", PRDATA, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        cycle();
        idle();

        // Auto-reload, period 5
        apb_write(4'd1, 32'd4, 4'hF);
        apb_write(4'd2, 32'd4, 4'hF);
        apb_write(4'd0, 32'h5, 4'hF);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'd2;
        for (int k = 0; k < 11; k++) begin
            #1;
            check("ar_count", PRDATA, seq[k]);
            check("ar_irq", 32'(irq_o), (k >= 5) ? 32'h1 : 32'h0);
            cycle();
        end
        idle();
        apb_write(4'd0, 32'h0, 4'hF);
        apb_write(4'd3, 32'h1, 4'hF);

        // One-shot, LOAD=2 PRESCALE=3: expiry 12 cycles after enabling
        apb_write(4'd1, 32'd2, 4'hF);
        apb_write(4'd2, 32'd2, 4'hF);
        apb_write(4'd0, 32'h0303, 4'hF);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'd3;
        for (int k = 0; k < 15; k++) begin
            #1;
            check("os_exp", PRDATA, (k >= 12) ? 32'h1 : 32'h0);
            cycle();
        end
        idle();
        apb_read_check(4'd0, 32'h0302, "os_ctrl");
        apb_read_check(4'd2, 32'h0, "os_count");
        apb_write(4'd3, 32'h1, 4'hF);
        repeat (100) cycle();
        apb_read_check(4'd3, 32'h0, "os_no_second");

        // W1C on the expiry cycle: set wins
        apb_write(4'd1, 32'd4, 4'hF);
        apb_write(4'd2, 32'd4, 4'hF);
        apb_write(4'd0, 32'h5, 4'hF);
        repeat (3) cycle();
        apb_write(4'd3, 32'h1, 4'hF);
        apb_read_check(4'd3, 32'h1, "w1c_race_exp");
        check("w1c_race_irq", 32'(irq_o), 32'h1);
        apb_write(4'd0, 32'h4, 4'hF);
        apb_write(4'd3, 32'h1, 4'hF);
        check("w1c_irq_clear", 32'(irq_o), 32'h0);
        apb_read_check(4'd3, 32'h0, "w1c_exp_clear");

        // COUNT write on a tick with COUNT=0: write wins, no expiry
        apb_write(4'd1, 32'h0, 4'hF);
        apb_write(4'd2, 32'h0, 4'hF);
        apb_write(4'd0, 32'h0301, 4'hF);
        repeat (2) cycle();
        apb_write(4'd2, 32'h10, 4'hF);
        apb_read_check(4'd2, 32'h10, "cw_count");
        apb_read_check(4'd3, 32'h0, "cw_no_exp");
        apb_write(4'd0, 32'h0, 4'hF);

        // Byte strobes
        apb_write(4'd1, 32'h0, 4'hF);
        apb_write(4'd1, 32'hAABBCCDD, 4'h1);
        apb_read_check(4'd1, 32'h000000DD, "strb_load");

        // Reset mid-count with irq asserted
        apb_write(4'd3, 32'h1, 4'hF);
        apb_write(4'd1, 32'd7, 4'hF);
        apb_write(4'd2, 32'h0, 4'hF);
        apb_write(4'd0, 32'h0105, 4'hF);
        apb_write(4'd0, 32'h0104, 4'hF);
        apb_read_check(4'd2, 32'd7, "pre_rst_count");
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        #2;
        PRESET = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'd2;
        #1;
        check("rst_async_irq", 32'(irq_o), 32'h0);
        check("rst_async_count", PRDATA, 32'h0);
        model_reset();
        repeat (3) cycle();
        idle();
        PRESET = 1'b0;
        repeat (20) cycle();
        apb_read_check(4'd2, 32'h0, "post_rst_count");
        apb_read_check(4'd0, 32'h0, "post_rst_ctrl");
        check("post_rst_irq", 32'(irq_o), 32'h0);

        // Randomized traffic checked by the compare process
        for (int n = 0; n < 1500; n++) begin
            logic [3:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            int unsigned r;
            r = $urandom_range(0, 9);
            a = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            d = $urandom;
            if (a == 4'd0) d[15:8] = 8'($urandom_range(0, 3));
            if ((a == 4'd1 || a == 4'd2) && $urandom_range(0, 7) != 0) d = $urandom_range(0, 12);
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'($urandom_range(0, 1));
            PADDR = a; PWDATA = d; PSTRB = s;
            cycle();
            PENABLE = 1'b1;
            cycle();
            idle();
            repeat ($urandom_range(0, 3)) begin
                PADDR  = 4'($urandom_range(0, 15));
                PWRITE = 1'($urandom_range(0, 1));
                cycle();
            end
            PWRITE = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
